// File: rtl/rpn_pkg.sv
// Shared definitions for the RPN engine: opcodes, error codes, FSM states.
// Latency: n/a (types and constant helpers only).
// Backpressure: n/a.
package rpn_pkg;

  typedef enum logic [3:0] {
    OP_PUSH   = 4'h0,
    OP_POP    = 4'h1,
    OP_DUP    = 4'h2,
    OP_SWAP   = 4'h3,
    OP_ADD    = 4'h4,
    OP_SUB    = 4'h5,
    OP_AND    = 4'h6,
    OP_OR     = 4'h7,
    OP_APPEND = 4'h8,
    OP_CLEAR  = 4'h9
  } op_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_UNDER   = 2'd1,
    ERR_OVER    = 2'd2,
    ERR_ILLEGAL = 2'd3
  } err_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2
  } state_e;

  // Address width for a memory of 'entries' words; never narrower than 1 bit.
  function automatic int addr_w(input int entries);
    return (entries > 1) ? $clog2(entries) : 1;
  endfunction

endpackage

// File: rtl/rpn_engine_if.sv
// Command/status bundle between a command source and the RPN engine.
// Latency: n/a (wiring only).
// Backpressure: source holds cmd_valid until cmd_ready is seen high.
interface rpn_engine_if #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64
);
  localparam int SW = $clog2(DEPTH + 1);

  logic              cmd_valid;
  logic              cmd_ready;
  logic [3:0]        cmd_op;
  logic [DATA_W-1:0] cmd_data;
  logic              done;
  logic [DATA_W-1:0] top;
  logic [SW-1:0]     size;
  logic              empty;
  logic              full;
  logic              err;
  logic [1:0]        err_code;

  modport master (
    output cmd_valid, cmd_op, cmd_data,
    input  cmd_ready, done, top, size, empty, full, err, err_code
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data,
    output cmd_ready, done, top, size, empty, full, err, err_code
  );

endinterface

// File: rtl/rpn_stack_mem.sv
// Below-top stack storage: one write port, one synchronous read port.
// Latency: read data valid one cycle after the address; same-cycle write to the read address is forwarded.
// Backpressure: none, accepts a read and a write every cycle.
module rpn_stack_mem #(
  parameter int DATA_W  = 32,
  parameter int ENTRIES = 63,
  parameter int AW      = 6
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [ENTRIES];

  // Array write; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  // Registered read, write-first so a just-spilled top is visible next cycle.
  always_ff @(posedge clk) begin
    rd_data <= (we && (wr_addr == rd_addr)) ? wr_data : mem[rd_addr];
  end

endmodule

// File: rtl/rpn_engine.sv
// RPN stack engine: top in a register, lower entries in rpn_stack_mem.
// Latency: done 1 cycle after accept; SWAP/ADD/SUB/AND/OR take 3 (IDLE->FETCH->EXEC).
// Backpressure: cmd_ready high only in IDLE, so one command in flight at a time.
module rpn_engine #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  parameter int IN_W   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  rpn_engine_if.slave bus
);
  import rpn_pkg::*;

  localparam int SW = $clog2(DEPTH + 1);
  localparam int AW = addr_w(DEPTH - 1);

  state_e            state_q, state_d;
  logic [SW-1:0]     size_q, size_d;
  logic [DATA_W-1:0] top_q, top_d;
  logic              err_q, err_d;
  logic [1:0]        code_q, code_d;
  logic              done_q, done_d;
  logic [3:0]        op_q, op_d;
  logic [DATA_W-1:0] opnd_q, opnd_d;

  logic              err_hit;
  logic [1:0]        err_kind;
  logic              empty_w, full_w;
  logic [SW-1:0]     below_idx, nos_idx, rd_idx;
  logic              mem_we;
  logic [AW-1:0]     mem_wa;
  logic [DATA_W-1:0] mem_wd;
  logic [DATA_W-1:0] mem_rd;

  assign empty_w   = (size_q == '0);
  assign full_w    = (size_q == SW'(DEPTH));
  assign below_idx = size_q - SW'(1);
  assign nos_idx   = size_q - SW'(2);
  // Read address tracks the size after this edge, so NOS is always ready next cycle.
  assign rd_idx    = (size_d >= SW'(2)) ? (size_d - SW'(2)) : '0;

  rpn_stack_mem #(
    .DATA_W  (DATA_W),
    .ENTRIES (DEPTH - 1),
    .AW      (AW)
  ) u_mem (
    .clk     (clk),
    .we      (mem_we),
    .wr_addr (mem_wa),
    .wr_data (mem_wd),
    .rd_addr (rd_idx[AW-1:0]),
    .rd_data (mem_rd)
  );

  // Next-state, datapath and memory control for every opcode.
  always_comb begin
    state_d  = state_q;
    size_d   = size_q;
    top_d    = top_q;
    err_d    = err_q;
    code_d   = code_q;
    done_d   = 1'b0;
    op_d     = op_q;
    opnd_d   = opnd_q;
    mem_we   = 1'b0;
    mem_wa   = below_idx[AW-1:0];
    mem_wd   = top_q;
    err_hit  = 1'b0;
    err_kind = ERR_NONE;
    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          done_d = 1'b1;
          case (bus.cmd_op)
            OP_PUSH: begin
              if (full_w) begin
                err_hit = 1'b1; err_kind = ERR_OVER;
              end else begin
                mem_we = !empty_w;
                size_d = size_q + SW'(1);
                top_d  = bus.cmd_data;
              end
            end
            OP_APPEND: begin
              if (empty_w) begin
                size_d = SW'(1);
                top_d  = {{(DATA_W-IN_W){1'b0}}, bus.cmd_data[IN_W-1:0]};
              end else begin
                top_d  = {top_q[DATA_W-IN_W-1:0], bus.cmd_data[IN_W-1:0]};
              end
            end
            OP_POP: begin
              if (empty_w) begin
                err_hit = 1'b1; err_kind = ERR_UNDER;
              end else begin
                size_d = size_q - SW'(1);
                top_d  = (size_q >= SW'(2)) ? mem_rd : '0;
              end
            end
            OP_DUP: begin
              if (empty_w) begin
                err_hit = 1'b1; err_kind = ERR_UNDER;
              end else if (full_w) begin
                err_hit = 1'b1; err_kind = ERR_OVER;
              end else begin
                mem_we = 1'b1;
                size_d = size_q + SW'(1);
              end
            end
            OP_CLEAR: begin
              size_d = '0;
              top_d  = '0;
              err_d  = 1'b0;
              code_d = ERR_NONE;
            end
            OP_SWAP, OP_ADD, OP_SUB, OP_AND, OP_OR: begin
              if (size_q < SW'(2)) begin
                err_hit = 1'b1; err_kind = ERR_UNDER;
              end else begin
                done_d  = 1'b0;
                op_d    = bus.cmd_op;
                state_d = FETCH;
              end
            end
            default: begin
              err_hit = 1'b1; err_kind = ERR_ILLEGAL;
            end
          endcase
        end
      end
      FETCH: begin
        opnd_d  = mem_rd;
        state_d = EXEC;
      end
      EXEC: begin
        done_d  = 1'b1;
        state_d = IDLE;
        case (op_q)
          OP_SWAP: begin
            mem_we = 1'b1;
            mem_wa = nos_idx[AW-1:0];
            top_d  = opnd_q;
          end
          OP_ADD: begin top_d = opnd_q + top_q; size_d = size_q - SW'(1); end
          OP_SUB: begin top_d = opnd_q - top_q; size_d = size_q - SW'(1); end
          OP_AND: begin top_d = opnd_q & top_q; size_d = size_q - SW'(1); end
          OP_OR:  begin top_d = opnd_q | top_q; size_d = size_q - SW'(1); end
          default: top_d = top_q;
        endcase
      end
      default: state_d = IDLE;
    endcase
    // Sticky error; only the first code since the last CLEAR is kept.
    if (err_hit) begin
      err_d = 1'b1;
      if (!err_q) code_d = err_kind;
    end
  end

  // State and datapath registers; reset aborts any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      size_q  <= '0;
      top_q   <= '0;
      err_q   <= 1'b0;
      code_q  <= ERR_NONE;
      done_q  <= 1'b0;
      op_q    <= '0;
      opnd_q  <= '0;
    end else begin
      state_q <= state_d;
      size_q  <= size_d;
      top_q   <= top_d;
      err_q   <= err_d;
      code_q  <= code_d;
      done_q  <= done_d;
      op_q    <= op_d;
      opnd_q  <= opnd_d;
    end
  end

  assign bus.cmd_ready = (state_q == IDLE);
  assign bus.done      = done_q;
  assign bus.top       = top_q;
  assign bus.size      = size_q;
  assign bus.empty     = empty_w;
  assign bus.full      = full_w;
  assign bus.err       = err_q;
  assign bus.err_code  = code_q;

endmodule
